// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and the writeback request bundle
// used by the regfile_scoreboard slice.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Widest data/address the writeback bundle can carry.
  localparam int MAX_XLEN = 64;
  localparam int MAX_AW   = 16;

  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_AW-1:0]   addr;
    logic [MAX_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: busy vector, busy_count, WAW issue gating, flush.
// REGFILE_BYPASS_EN: a same-cycle writeback to issue_rd also makes issue_ready 1.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic             flush,
  output logic             issue_ready,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  logic             issue_zero;
  logic             wb_eff;
  logic             set_en;
  logic             inc;
  logic             dec;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      count_next;

  assign issue_zero = (ZERO_REG != 0) && (issue_rd == '0);
  assign wb_eff     = wb_valid && !((ZERO_REG != 0) && (wb_addr == '0));

`ifdef REGFILE_BYPASS_EN
  assign issue_ready = issue_zero || !busy[issue_rd] || (wb_eff && (wb_addr == issue_rd));
`else
  assign issue_ready = issue_zero || !busy[issue_rd];
`endif

  // A flushed or register-0 reservation is accepted but leaves no trace.
  assign set_en = issue_valid && issue_ready && !issue_zero && !flush;

  always_comb begin
    busy_next = busy;
    if (wb_eff) busy_next[wb_addr] = 1'b0;
    if (set_en) busy_next[issue_rd] = 1'b1;
    if (flush)  busy_next = '0;
  end

  // Same-register issue+writeback keeps the bit set, so no decrement then.
  assign inc = set_en && !busy[issue_rd];
  assign dec = wb_eff && busy[wb_addr] && !(set_en && (issue_rd == wb_addr));

  assign count_next = flush ? '0 : (busy_count + (AW+1)'(inc) - (AW+1)'(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational multi-port reads and an integrated busy scoreboard.
// REGFILE_BYPASS_EN: same-cycle writeback data/busy forwarded to matching read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREAD-1:0][AW-1:0]   rd_addr,
  output logic [NREAD-1:0][XLEN-1:0] rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       flush,
  output logic [AW:0]                busy_count
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  wb_req_t          wb_req;
  logic [AW-1:0]    wb_addr_int;
  logic [XLEN-1:0]  wb_data_int;
  logic             wb_eff;
  logic             unused_wb;

  // Bundle carries at most MAX_XLEN data bits and MAX_AW address bits.
  always_comb begin
    wb_req.valid = wb_valid;
    wb_req.addr  = MAX_AW'(wb_addr);
    wb_req.data  = MAX_XLEN'(wb_data);
  end

  assign wb_addr_int = wb_req.addr[AW-1:0];
  assign wb_data_int = wb_req.data[XLEN-1:0];
  assign wb_eff      = wb_req.valid && !((ZERO_REG != 0) && (wb_addr_int == '0));
  assign unused_wb   = ^wb_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wb_eff) begin
      mem[wb_addr_int] <= wb_data_int;
    end
  end

  regfile_busy_tracker #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_req.valid),
    .wb_addr     (wb_addr_int),
    .flush       (flush),
    .issue_ready (issue_ready),
    .busy        (busy),
    .busy_count  (busy_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic hit;
`ifdef REGFILE_BYPASS_EN
      assign hit = wb_eff && (wb_addr_int == rd_addr[gi]);
`else
      assign hit = 1'b0;
`endif
      assign rd_data[gi] = hit ? wb_data_int : mem[rd_addr[gi]];
      assign rd_busy[gi] = hit ? 1'b0 : busy[rd_addr[gi]];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a reference model pushes expected
// outputs at drive time; they are popped and compared once the DUT settles.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREAD-1:0][AW-1:0]   rd_addr;
  logic [NREAD-1:0][XLEN-1:0] rd_data;
  logic [NREAD-1:0]           rd_busy;
  logic                       issue_valid;
  logic [AW-1:0]              issue_rd;
  logic                       issue_ready;
  logic                       wb_valid;
  logic [AW-1:0]              wb_addr;
  logic [XLEN-1:0]            wb_data;
  logic                       flush;
  logic [AW:0]                busy_count;

  always #50 clk = ~clk;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .busy_count(busy_count)
  );

  // Reference model
  logic [XLEN-1:0]  m_data [NREGS];
  logic [NREGS-1:0] m_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 issue_ready, 3 busy_count
    int          port;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_data[r] = '0;
    m_busy = '0;
  endtask

  function automatic bit wb_hits(input int a);
    return BYP && wb_valid && (int'(wb_addr) == a) && (a != 0);
  endfunction

  function automatic bit m_ready();
    return (issue_rd == '0) || !m_busy[issue_rd] || wb_hits(int'(issue_rd));
  endfunction

  task automatic push(input string tag, input int kind, input int port, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       got = 64'(rd_data[e.port]);
        1:       got = 64'(rd_busy[e.port]);
        2:       got = 64'(issue_ready);
        default: got = 64'(busy_count);
      endcase
      check_val(e.tag, got, e.exp);
    end
  endtask

  // Drive read addresses, queue the model's view, then compare once settled.
  task automatic probe(input string tag, input int a0, input int a1);
    int a;
    rd_addr[0] = AW'(a0);
    rd_addr[1] = AW'(a1);
    for (int p = 0; p < NREAD; p++) begin
      a = (p == 0) ? a0 : a1;
      push($sformatf("%s.data%0d[r%0d]", tag, p, a), 0, p,
           64'(wb_hits(a) ? wb_data : m_data[a]));
      push($sformatf("%s.busy%0d[r%0d]", tag, p, a), 1, p,
           64'(wb_hits(a) ? 1'b0 : m_busy[a]));
    end
    push($sformatf("%s.issue_ready", tag), 2, 0, 64'(m_ready()));
    push($sformatf("%s.busy_count", tag), 3, 0, 64'($countones(m_busy)));
    #1;
    $display("txn %-12s rd0=r%0d:0x%0h rd1=r%0d:0x%0h rdy=%0b cnt=%0d",
             tag, a0, rd_data[0], a1, rd_data[1], issue_ready, busy_count);
    drain();
  endtask

  // Commit current inputs to the model, advance one edge, release strobes.
  task automatic step();
    logic [NREGS-1:0] nb;
    bit acc;
    nb  = m_busy;
    acc = issue_valid && m_ready() && (issue_rd != '0) && !flush;
    if (wb_valid && (wb_addr != '0)) begin
      m_data[wb_addr] = wb_data;
      nb[wb_addr] = 1'b0;
    end
    if (acc)   nb[issue_rd] = 1'b1;
    if (flush) nb = '0;
    m_busy = nb;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_wb(input int a, input logic [XLEN-1:0] d);
    wb_valid = 1'b1; wb_addr = AW'(a); wb_data = d;
  endtask

  task automatic do_issue(input int a);
    issue_valid = 1'b1; issue_rd = AW'(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_addr = '0; issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    model_reset();
    #5;
    for (int a = 0; a < 16; a++) probe("reset", a, a + 16);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int r = 1; r < NREGS; r++) begin
      do_wb(r, 32'h19);
      step();
    end
    do_wb(0, 32'h77);
    step();
    for (int a = 0; a < 16; a++) probe("rdback", a, a + 16);

    do_issue(5); probe("iss5", 5, 0); step();
    do_issue(5); probe("iss5_again", 5, 0); step();
    do_wb(5, 32'hAB); probe("wb5", 5, 0); step();
    probe("after_wb5", 5, 0);
    do_issue(5); probe("reiss5", 5, 0); step();
    probe("busy5", 5, 0);
    do_wb(5, 32'h05); step();

    do_issue(7); do_wb(7, 32'h3C); probe("iw7", 7, 0); step();
    probe("iw7_after", 7, 0);
    do_wb(7, 32'h07); step();

    do_issue(10); step();
    do_issue(11); step();
    do_issue(12); step();
    probe("pre_flush", 10, 12);
    flush = 1'b1; do_wb(9, 32'h99); do_issue(13);
    probe("flush_cyc", 9, 13); step();
    probe("post_flush", 9, 13);

    do_issue(3); step();
    do_wb(3, 32'h55); probe("byp3", 3, 3); step();
    probe("byp3_after", 3, 3);

    do_issue(4); step();
    do_issue(4); do_wb(4, 32'h44); probe("waw4", 4, 4); step();
    probe("waw4_after", 4, 4);

    do_issue(20); step();
    #10;
    rst = 1'b1;
    model_reset();
    probe("arst", 20, 9);
    #10;
    rst = 1'b0;
    do_issue(21); step();
    probe("post_rst", 21, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
